adc_scan_sequencer: RTL and testbench

//  Sequences conversions on the 8-channel 10-bit SPI ADC (MCP3008-style frame: START, SGL, D2..D0, null, B9..B0).

---
 rtl/adc_scan_sequencer.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_sequencer
// Description : Scan sequencer for an 8-channel 10-bit SPI ADC using the
//               MCP3008-style frame (START, SGL, D2..D0, null, B9..B0).
//               Walks the enabled channels in ascending order, one CS frame
//               per channel. Generates AD_CLK/CS/DIN and deserialises DOUT
//               into a tagged result with a one-clock valid strobe.
//
// Ports       : clk, rst          - system clock, async active-high reset
//               ch_enable[7:0]    - channel mask, latched when a scan starts
//               single_ended      - SGL command bit, latched per frame
//               scan_start        - one-clock start request (ignored if busy)
//               continuous        - restart automatically after the last channel
//               busy, scan_done   - scan status / one-clock end-of-scan pulse
//               result_data[9:0]  - last conversion (B9 = MSB)
//               result_ch[2:0]    - channel of result_data
//               result_valid      - one-clock strobe on result update
//               AD_CLK, CS, DIN   - SPI outputs (idle 0 / 1 / 0)
//               DOUT              - SPI data in, resynchronised with 2 flops
//
// Revision    : 1.0 - initial release
// ============================================================================
module adc_scan_sequencer #(
    parameter int CLK_DIV = 27,  // clk cycles per AD_CLK half-period (>= 2)
    parameter int CS_GAP  = 2    // AD_CLK periods with CS high between frames (>= 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ch_enable,
    input  logic       single_ended,
    input  logic       scan_start,
    input  logic       continuous,
    output logic       busy,
    output logic       scan_done,
    output logic [9:0] result_data,
    output logic [2:0] result_ch,
    output logic       result_valid,
    output logic       AD_CLK,
    output logic       CS,
    output logic       DIN,
    input  logic       DOUT
);

    localparam int c_CNT_W = $clog2(CLK_DIV);
    localparam int c_GAP_W = $clog2(2 * CS_GAP);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_SELECT = 3'd1;
    localparam logic [2:0] c_S_SHIFT  = 3'd2;
    localparam logic [2:0] c_S_DONE   = 3'd3;
    localparam logic [2:0] c_S_GAP    = 3'd4;

    localparam logic [4:0] c_LAST_RISE = 5'd17;

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    logic [2:0]         r_state, w_state_nxt;
    logic [7:0]         r_mask,  w_mask_nxt;
    logic [2:0]         r_ch,    w_ch_nxt;
    logic               r_sgl,   w_sgl_nxt;
    logic [4:0]         r_rise,  w_rise_nxt;   // rising edges seen in this frame
    logic               r_sclk,  w_sclk_nxt;
    logic               r_cs,    w_cs_nxt;
    logic               r_din,   w_din_nxt;
    logic [9:0]         r_shift, w_shift_nxt;
    logic               r_busy,  w_busy_nxt;
    logic               r_done,  w_done_nxt;
    logic [9:0]         r_res_data,  w_res_data_nxt;
    logic [2:0]         r_res_ch,    w_res_ch_nxt;
    logic               r_res_valid, w_res_valid_nxt;
    logic [c_GAP_W-1:0] r_gap,   w_gap_nxt;    // ticks spent in GAP
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_dout_meta, r_dout_sync;

    logic               w_tick;
    logic               w_frame_go;
    logic [2:0]         w_next_ch;
    logic               w_has_next;

    // Lowest set bit of a channel mask (0 when the mask is empty).
    function automatic logic [2:0] f_lowest(input logic [7:0] m);
        f_lowest = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) f_lowest = 3'(i);
        end
    endfunction

    // ------------------------------------------------------------------
    // Half-period divider. Held at zero while idle and during the single
    // DONE clock so that GAP and every SELECT start on a fresh period.
    // ------------------------------------------------------------------
    assign w_tick = (r_cnt == c_CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == c_S_IDLE || r_state == c_S_DONE || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // DOUT comes from another clock domain (the ADC's own output stage).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout_meta <= 1'b0;
            r_dout_sync <= 1'b0;
        end else begin
            r_dout_meta <= DOUT;
            r_dout_sync <= r_dout_meta;
        end
    end

    // Next enabled channel strictly above the current one in the latched mask.
    always_comb begin
        w_next_ch  = 3'd0;
        w_has_next = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (r_mask[i] && (3'(i) > r_ch)) begin
                w_next_ch  = 3'(i);
                w_has_next = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_mask      <= 8'd0;
            r_ch        <= 3'd0;
            r_sgl       <= 1'b0;
            r_rise      <= 5'd0;
            r_sclk      <= 1'b0;
            r_cs        <= 1'b1;
            r_din       <= 1'b0;
            r_shift     <= 10'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_res_data  <= 10'd0;
            r_res_ch    <= 3'd0;
            r_res_valid <= 1'b0;
            r_gap       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mask      <= w_mask_nxt;
            r_ch        <= w_ch_nxt;
            r_sgl       <= w_sgl_nxt;
            r_rise      <= w_rise_nxt;
            r_sclk      <= w_sclk_nxt;
            r_cs        <= w_cs_nxt;
            r_din       <= w_din_nxt;
            r_shift     <= w_shift_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_res_data  <= w_res_data_nxt;
            r_res_ch    <= w_res_ch_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_gap       <= w_gap_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_mask_nxt      = r_mask;
        w_ch_nxt        = r_ch;
        w_sgl_nxt       = r_sgl;
        w_rise_nxt      = r_rise;
        w_sclk_nxt      = r_sclk;
        w_cs_nxt        = r_cs;
        w_din_nxt       = r_din;
        w_shift_nxt     = r_shift;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_res_data_nxt  = r_res_data;
        w_res_ch_nxt    = r_res_ch;
        w_res_valid_nxt = 1'b0;
        w_gap_nxt       = r_gap;
        w_frame_go      = 1'b0;

        case (r_state)
            c_S_IDLE: begin
                if (scan_start) begin
                    w_mask_nxt = ch_enable;
                    if (ch_enable != 8'd0) begin
                        w_busy_nxt = 1'b1;
                        w_ch_nxt   = f_lowest(ch_enable);
                        w_frame_go = 1'b1;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end

            c_S_SELECT: begin
                // START is already on DIN; wait one half-period before clocking.
                if (w_tick) w_state_nxt = c_S_SHIFT;
            end

            c_S_SHIFT: begin
                if (w_tick) begin
                    if (r_sclk) begin
                        // Falling edge: present the bit for the next rise.
                        w_sclk_nxt = 1'b0;
                        if (r_rise == c_LAST_RISE) begin
                            w_state_nxt = c_S_DONE;
                            w_cs_nxt    = 1'b1;
                            w_din_nxt   = 1'b0;
                        end else begin
                            case (r_rise)
                                5'd1:    w_din_nxt = r_sgl;
                                5'd2:    w_din_nxt = r_ch[2];
                                5'd3:    w_din_nxt = r_ch[1];
                                5'd4:    w_din_nxt = r_ch[0];
                                default: w_din_nxt = 1'b0;
                            endcase
                        end
                    end else begin
                        // Rising edge r_rise+1; rises 8..17 carry B9..B0.
                        w_sclk_nxt = 1'b1;
                        w_rise_nxt = r_rise + 5'd1;
                        if (r_rise >= 5'd7) w_shift_nxt = {r_shift[8:0], r_dout_sync};
                    end
                end
            end

            c_S_DONE: begin
                w_res_data_nxt  = r_shift;
                w_res_ch_nxt    = r_ch;
                w_res_valid_nxt = 1'b1;
                w_gap_nxt       = '0;
                w_state_nxt     = c_S_GAP;
            end

            c_S_GAP: begin
                if (w_tick) begin
                    if (r_gap == c_GAP_W'(2 * CS_GAP - 1)) begin
                        if (w_has_next) begin
                            w_ch_nxt   = w_next_ch;
                            w_frame_go = 1'b1;
                        end else if (continuous && (ch_enable != 8'd0)) begin
                            w_mask_nxt = ch_enable;
                            w_ch_nxt   = f_lowest(ch_enable);
                            w_frame_go = 1'b1;
                        end else begin
                            if (continuous) w_mask_nxt = ch_enable;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                            w_state_nxt = c_S_IDLE;
                        end
                    end else begin
                        w_gap_nxt = r_gap + c_GAP_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase

        // Common frame start: CS low with START already on DIN.
        if (w_frame_go) begin
            w_state_nxt = c_S_SELECT;
            w_cs_nxt    = 1'b0;
            w_din_nxt   = 1'b1;
            w_sclk_nxt  = 1'b0;
            w_sgl_nxt   = single_ended;
            w_rise_nxt  = 5'd0;
        end
    end

    assign busy         = r_busy;
    assign scan_done    = r_done;
    assign result_data  = r_res_data;
    assign result_ch    = r_res_ch;
    assign result_valid = r_res_valid;
    assign AD_CLK       = r_sclk;
    assign CS           = r_cs;
    assign DIN          = r_din;

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_scan_sequencer
// Description : Self-checking bench for adc_scan_sequencer. An ADC model
//               decodes the command bits, serves a random 10-bit code per
//               frame and records frame timing; expected results come from a
//               channel queue built from the mask in ascending order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_scan_sequencer;

    localparam int c_CLK_DIV = 2;
    localparam int c_CS_GAP  = 2;
    localparam int c_LAT     = 35 * c_CLK_DIV + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ch_enable = 8'd0;
    logic       single_ended = 1'b0;
    logic       scan_start = 1'b0;
    logic       continuous = 1'b0;
    logic       busy, scan_done, result_valid;
    logic [9:0] result_data;
    logic [2:0] result_ch;
    logic       AD_CLK, CS, DIN;
    logic       DOUT = 1'b0;

    always #5 clk = ~clk;

    adc_scan_sequencer #(.CLK_DIV(c_CLK_DIV), .CS_GAP(c_CS_GAP)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .ch_enable    (ch_enable),
        .single_ended (single_ended),
        .scan_start   (scan_start),
        .continuous   (continuous),
        .busy         (busy),
        .scan_done    (scan_done),
        .result_data  (result_data),
        .result_ch    (result_ch),
        .result_valid (result_valid),
        .AD_CLK       (AD_CLK),
        .CS           (CS),
        .DIN          (DIN),
        .DOUT         (DOUT)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    typedef struct {
        logic [4:0] cmd;
        logic [9:0] code;
        int         t_fall;
    } frame_t;

    logic [2:0] exp_ch[$];
    frame_t     frames[$];
    logic       exp_sgl = 1'b0;
    int         force_code = -1;

    // ADC model / bus monitor
    logic       prev_cs = 1'b1, prev_sclk = 1'b0, prev_din = 1'b0;
    int         rise_n = 0, proto_err = 0, n_csfall = 0;
    int         t_csfall = 0, t_edge = 0, t_csrise = 0;
    logic       have_rise = 1'b0;
    logic [4:0] cmd = 5'd0;
    logic [9:0] code = 10'd0;
    logic [3:0] bi;
    int         nb;
    frame_t     fr;
    logic [2:0] ech;

    always @(negedge clk) begin
        if (rst) begin
            prev_cs   = 1'b1;
            prev_sclk = 1'b0;
            prev_din  = 1'b0;
            rise_n    = 0;
            have_rise = 1'b0;
            frames.delete();
            DOUT      = 1'b0;
        end else begin
            if (prev_cs && !CS) begin
                n_csfall++;
                rise_n    = 0;
                cmd       = 5'd0;
                proto_err = 0;
                code      = (force_code >= 0) ? 10'(force_code) : 10'($urandom_range(0, 1023));
                t_csfall  = cyc;
                if (have_rise)
                    check("cs_gap", 32'((cyc - t_csrise) >= 2 * c_CS_GAP * c_CLK_DIV), 32'd1);
            end else if ((DIN != prev_din) && !(prev_sclk && !AD_CLK)) begin
                proto_err++;
            end

            if (!prev_sclk && AD_CLK) begin
                rise_n++;
                if (rise_n == 1) begin
                    if (cyc - t_csfall != 2 * c_CLK_DIV) proto_err++;
                end else if (cyc - t_edge != c_CLK_DIV) begin
                    proto_err++;
                end
                t_edge = cyc;
                if (rise_n <= 5) cmd = {cmd[3:0], DIN};
                else if (DIN) proto_err++;
                // Present the next bit right after this rise so it is stable
                // through the DUT's two-flop synchroniser at the minimum divider.
                nb = rise_n + 1;
                if (nb >= 8 && nb <= 17) begin
                    bi   = 4'(17 - nb);
                    DOUT = code[bi];
                end else begin
                    DOUT = 1'($urandom_range(0, 1));
                end
            end

            if (prev_sclk && !AD_CLK) begin
                if (cyc - t_edge != c_CLK_DIV) proto_err++;
                t_edge = cyc;
            end

            if (!prev_cs && CS) begin
                check("rises", 32'(rise_n), 32'd17);
                check("protocol", 32'(proto_err), 32'd0);
                fr.cmd    = cmd;
                fr.code   = code;
                fr.t_fall = t_csfall;
                frames.push_back(fr);
                t_csrise  = cyc;
                have_rise = 1'b1;
            end

            if (result_valid) begin
                check("res_expected", 32'((exp_ch.size() != 0) && (frames.size() != 0)), 32'd1);
                if ((exp_ch.size() != 0) && (frames.size() != 0)) begin
                    ech = exp_ch.pop_front();
                    fr  = frames.pop_front();
                    check("res_ch", 32'(result_ch), 32'(ech));
                    check("res_data", 32'(result_data), 32'(fr.code));
                    check("cmd_bits", 32'(fr.cmd), 32'({1'b1, exp_sgl, ech}));
                    check("latency", 32'(cyc - fr.t_fall), 32'(c_LAT));
                end
            end

            prev_cs   = CS;
            prev_sclk = AD_CLK;
            prev_din  = DIN;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic wait_done(input bit stress, output int n);
        n = 0;
        while (!scan_done && n < 20000) begin
            @(negedge clk);
            n++;
            scan_start = !scan_done && stress && ($urandom_range(0, 49) == 0);
        end
        scan_start = 1'b0;
    endtask

    task automatic run_scan(input logic [7:0] mask, input bit sgl, input bit stress, input bit mid_change);
        int n;
        int falls0;
        falls0       = n_csfall;
        ch_enable    = mask;
        single_ended = sgl;
        exp_sgl      = sgl;
        continuous   = 1'b0;
        for (int i = 0; i < 8; i++) if (mask[i]) exp_ch.push_back(3'(i));
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        check("busy_start", 32'(busy), 32'(mask != 8'd0));
        if (mid_change) ch_enable = 8'($urandom);
        wait_done(stress, n);
        check("scan_done", 32'(scan_done), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
        check("all_results", 32'(exp_ch.size()), 32'd0);
        if (mask == 8'd0) begin
            check("zero_latency", 32'(n), 32'd0);
            check("zero_no_cs", 32'(n_csfall - falls0), 32'd0);
        end else begin
            check("frames", 32'(n_csfall - falls0), 32'($countones(mask)));
        end
        @(negedge clk);
        check("done_pulse", 32'(scan_done), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int falls0;

        repeat (3) @(negedge clk);
        check("rst_cs", 32'(CS), 32'd1);
        check("rst_adclk", 32'(AD_CLK), 32'd0);
        check("rst_din", 32'(DIN), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(scan_done), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_data", 32'(result_data), 32'd0);
        check("rst_ch", 32'(result_ch), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single channel 0, fixed code
        force_code = 10'h2A5;
        run_scan(8'h01, 1'b1, 1'b0, 1'b0);
        check("t1_data", 32'(result_data), 32'h2A5);
        check("t1_ch", 32'(result_ch), 32'd0);
        force_code = -1;

        // Sparse mask, mask changed mid-scan
        run_scan(8'hA4, 1'($urandom_range(0, 1)), 1'b0, 1'b1);

        // Empty mask
        run_scan(8'h00, 1'b0, 1'b0, 1'b0);

        // Continuous 0,7,0,7,... then drop continuous in the third channel-0 frame
        falls0       = n_csfall;
        ch_enable    = 8'h81;
        single_ended = 1'b0;
        exp_sgl      = 1'b0;
        continuous   = 1'b1;
        repeat (3) begin
            exp_ch.push_back(3'd0);
            exp_ch.push_back(3'd7);
        end
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        n = 0;
        while ((n_csfall - falls0) < 5 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("cont_reach", 32'(n_csfall - falls0), 32'd5);
        continuous = 1'b0;
        wait_done(1'b0, n);
        check("cont_done", 32'(scan_done), 32'd1);
        check("cont_busy", 32'(busy), 32'd0);
        check("cont_results", 32'(exp_ch.size()), 32'd0);
        check("cont_frames", 32'(n_csfall - falls0), 32'd6);
        @(negedge clk);

        // Reset in the middle of a frame
        ch_enable    = 8'hFF;
        single_ended = 1'b1;
        exp_sgl      = 1'b1;
        for (int i = 0; i < 8; i++) exp_ch.push_back(3'(i));
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        n = 0;
        while (rise_n != 10 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach", 32'(rise_n), 32'd10);
        #2 rst = 1'b1;
        #1;
        check("abort_cs", 32'(CS), 32'd1);
        check("abort_adclk", 32'(AD_CLK), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(result_valid), 32'd0);
        exp_ch.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (60) begin
            @(negedge clk);
            if (result_valid || scan_done || !CS) n++;
        end
        check("post_rst_quiet", 32'(n), 32'd0);
        run_scan(8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);

        // Random scans with ignored scan_start pulses and mid-scan mask changes
        repeat (8) begin
            run_scan(8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
